// File: rtl/score_argmax.sv
// Argmax / runner-up evaluator for a packed score vector: snapshots the scores on
// start, scans one score per cycle, then reports winner, runner-up, margin and confidence.
module score_argmax #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 16,
  parameter int SIGNED    = 1,
  parameter int TIE_LAST  = 0,
  localparam int IDX_W    = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_CLASSES*SCORE_W-1:0] scores_in,
  input  logic [SCORE_W-1:0]           threshold,
  output logic                         busy,
  output logic                         done,
  output logic [IDX_W-1:0]             pred_class,
  output logic [SCORE_W-1:0]           max_score,
  output logic [IDX_W-1:0]             second_class,
  output logic [SCORE_W:0]             margin,
  output logic                         confident
);

  typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  state_t                       state;
  logic [N_CLASSES*SCORE_W-1:0] snap;
  logic [SCORE_W-1:0]           thr_q;
  logic [IDX_W-1:0]             idx;
  logic [SCORE_W-1:0]           best;
  logic [SCORE_W-1:0]           second;
  logic [IDX_W-1:0]             best_idx;
  logic [IDX_W-1:0]             second_idx;
  logic                         second_valid;

  logic [SCORE_W-1:0]           cur;
  logic                         beats_best;
  logic                         beats_second;
  logic [SCORE_W:0]             best_x;
  logic [SCORE_W:0]             second_x;
  logic [SCORE_W:0]             diff;

  // True when a displaces b under the configured signedness and tie policy.
  function automatic logic beats(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic gt;
    if (SIGNED != 0) gt = $signed(a) > $signed(b);
    else             gt = a > b;
    if (TIE_LAST != 0) return gt || (a == b);
    else               return gt;
  endfunction

  // The snapshot shifts down one score per SCAN cycle, so the current score is always the low slice.
  assign cur          = snap[SCORE_W-1:0];
  assign beats_best   = beats(cur, best);
  assign beats_second = beats(cur, second);

  always_comb begin
    best_x   = '0;
    second_x = '0;
    if (SIGNED != 0) begin
      best_x   = {best[SCORE_W-1], best};
      second_x = {second[SCORE_W-1], second};
    end else begin
      best_x   = {1'b0, best};
      second_x = {1'b0, second};
    end
    diff = second_valid ? (best_x - second_x) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      snap         <= '0;
      thr_q        <= '0;
      idx          <= '0;
      best         <= '0;
      second       <= '0;
      best_idx     <= '0;
      second_idx   <= '0;
      second_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pred_class   <= '0;
      max_score    <= '0;
      second_class <= '0;
      margin       <= '0;
      confident    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= scores_in;
            thr_q <= threshold;
            idx   <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (idx == '0) begin
            best         <= cur;
            best_idx     <= '0;
            second_valid <= 1'b0;
          end else if (beats_best) begin
            second       <= best;
            second_idx   <= best_idx;
            best         <= cur;
            best_idx     <= idx;
            second_valid <= 1'b1;
          end else if (!second_valid || beats_second) begin
            second       <= cur;
            second_idx   <= idx;
            second_valid <= 1'b1;
          end
          snap <= snap >> SCORE_W;
          if (idx == LAST_IDX) state <= RESULT;
          else                 idx   <= idx + 1'b1;
        end
        RESULT: begin
          pred_class   <= best_idx;
          max_score    <= best;
          second_class <= second_valid ? second_idx : '0;
          margin       <= diff;
          confident    <= diff >= {1'b0, thr_q};
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_argmax.sv
// Bench for score_argmax: five parameterisations share start/reset; table vectors,
// multi-cycle corner sequences and randomized runs against a two-pass argmax model.
module tb_score_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [159:0] scores;
  logic [127:0] scores16;
  logic [15:0]  thr;

  logic       busy0, done0, conf0;  logic [3:0] pred0, sec0;  logic [15:0] max0;  logic [16:0] marg0;
  logic       busy1, done1, conf1;  logic [3:0] pred1, sec1;  logic [15:0] max1;  logic [16:0] marg1;
  logic       busy2, done2, conf2;  logic [3:0] pred2, sec2;  logic [15:0] max2;  logic [16:0] marg2;
  logic       busy3, done3, conf3;  logic [0:0] pred3, sec3;  logic [15:0] max3;  logic [16:0] marg3;
  logic       busy4, done4, conf4;  logic [3:0] pred4, sec4;  logic [7:0]  max4;  logic [8:0]  marg4;

  logic [4:0] busy_vec, done_vec;
  assign busy_vec = {busy4, busy3, busy2, busy1, busy0};
  assign done_vec = {done4, done3, done2, done1, done0};

  score_argmax u0 (.clk(clk), .rst(rst), .start(start), .scores_in(scores), .threshold(thr),
    .busy(busy0), .done(done0), .pred_class(pred0), .max_score(max0), .second_class(sec0),
    .margin(marg0), .confident(conf0));
  score_argmax #(.SIGNED(0)) u1 (.clk(clk), .rst(rst), .start(start), .scores_in(scores), .threshold(thr),
    .busy(busy1), .done(done1), .pred_class(pred1), .max_score(max1), .second_class(sec1),
    .margin(marg1), .confident(conf1));
  score_argmax #(.TIE_LAST(1)) u2 (.clk(clk), .rst(rst), .start(start), .scores_in(scores), .threshold(thr),
    .busy(busy2), .done(done2), .pred_class(pred2), .max_score(max2), .second_class(sec2),
    .margin(marg2), .confident(conf2));
  score_argmax #(.N_CLASSES(1)) u3 (.clk(clk), .rst(rst), .start(start), .scores_in(scores[15:0]),
    .threshold(thr), .busy(busy3), .done(done3), .pred_class(pred3), .max_score(max3),
    .second_class(sec3), .margin(marg3), .confident(conf3));
  score_argmax #(.N_CLASSES(16), .SCORE_W(8)) u4 (.clk(clk), .rst(rst), .start(start),
    .scores_in(scores16), .threshold(thr[7:0]), .busy(busy4), .done(done4), .pred_class(pred4),
    .max_score(max4), .second_class(sec4), .margin(marg4), .confident(conf4));

  int n_chk  = 0;
  int n_pass = 0;
  logic [41:0] exp_q[$];
  int lat_exp[5] = '{11, 11, 11, 2, 17};

  typedef struct {
    string        name;
    int           inst;
    logic [159:0] sc;
    logic [127:0] sc16;
    logic [15:0]  th;
    logic [41:0]  exp;
  } vec_t;

  // Result record layout: {pred[3:0], max[15:0], second[3:0], margin[16:0], confident}.
  function automatic logic [41:0] pack(input logic [3:0] p, input logic [15:0] m,
                                       input logic [3:0] s, input logic [16:0] g, input logic c);
    return {p, m, s, g, c};
  endfunction

  function automatic logic [41:0] get_res(input int k);
    case (k)
      0: return {pred0, max0, sec0, marg0, conf0};
      1: return {pred1, max1, sec1, marg1, conf1};
      2: return {pred2, max2, sec2, marg2, conf2};
      3: return {3'b000, pred3, max3, 3'b000, sec3, marg3, conf3};
      4: return {pred4, 8'h00, max4, sec4, 8'h00, marg4, conf4};
      default: return '0;
    endcase
  endfunction

  function automatic logic [159:0] fill(input logic [15:0] base, input int i1, input logic [15:0] v1,
                                        input int i2, input logic [15:0] v2);
    logic [159:0] r;
    for (int i = 0; i < 10; i++) r[i*16 +: 16] = base;
    r[i1*16 +: 16] = v1;
    r[i2*16 +: 16] = v2;
    return r;
  endfunction

  // Reference: winner is the extreme value (first or last index on ties), runner-up
  // is the extreme value among all remaining indices under the same tie rule.
  function automatic logic [41:0] model(input logic [159:0] sv, input bit sgn, input bit tl,
                                        input logic [15:0] th);
    longint v[10];
    longint mx, sx, mg;
    int w, si;
    for (int i = 0; i < 10; i++) begin
      logic [15:0] s;
      s = sv[i*16 +: 16];
      v[i] = sgn ? longint'($signed(s)) : longint'(s);
    end
    mx = v[0];
    for (int i = 1; i < 10; i++) if (v[i] > mx) mx = v[i];
    w = -1;
    for (int i = 0; i < 10; i++) if (v[i] == mx && (w < 0 || tl)) w = i;
    si = -1; sx = 0;
    for (int i = 0; i < 10; i++) begin
      if (i != w && (si < 0 || v[i] > sx || (v[i] == sx && tl))) begin
        si = i;
        sx = v[i];
      end
    end
    mg = mx - sx;
    return pack(4'(w), sv[w*16 +: 16], 4'(si), 17'(mg), mg >= longint'(th));
  endfunction

  function automatic logic [15:0] rnd_score();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      4: return 16'h0100;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_res(input string nm, input logic [41:0] got, input logic [41:0] exp);
    chk({nm, ".pred"},   64'(got[41:38]), 64'(exp[41:38]));
    chk({nm, ".max"},    64'(got[37:22]), 64'(exp[37:22]));
    chk({nm, ".second"}, 64'(got[21:18]), 64'(exp[21:18]));
    chk({nm, ".margin"}, 64'(got[17:1]),  64'(exp[17:1]));
    chk({nm, ".conf"},   64'(got[0]),     64'(exp[0]));
  endtask

  task automatic do_start(input int hold);
    int t;
    t = 0;
    while (busy_vec != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("idle_wait", 64'(busy_vec), 64'd0);
    start = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (lat < 60) begin
      if (busy_vec[k]) bc++;
      @(posedge clk); #1;
      lat++;
      if (done_vec[k]) break;
    end
  endtask

  task automatic run_inst(input int k, input string nm, input logic [41:0] exp);
    int lat, bc;
    do_start(1);
    wait_done(k, lat, bc);
    chk({nm, ".latency"}, 64'(lat), 64'(lat_exp[k]));
    chk({nm, ".busy_cycles"}, 64'(bc), 64'(lat_exp[k]));
    chk_res(nm, get_res(k), exp);
  endtask

  vec_t vecs[9];
  logic [41:0] exp_def;

  initial begin
    logic [127:0] ramp;
    logic [41:0]  got;
    int n;

    rst = 1'b1; start = 1'b0; scores = '0; scores16 = '0; thr = '0;
    for (int i = 0; i < 16; i++) ramp[i*8 +: 8] = 8'(120 - 5 * i);
    exp_def = pack(4'd3, 16'h0480, 4'd7, 17'h00180, 1'b1);

    vecs[0] = '{"default",   0, fill(16'h0040, 3, 16'h0480, 7, 16'h0300), '0, 16'h0100, exp_def};
    vecs[1] = '{"signed_s1", 0, fill(16'h0000, 2, 16'h0100, 5, 16'hFF00), '0, 16'h0100,
                pack(4'd2, 16'h0100, 4'd0, 17'h00100, 1'b1)};
    vecs[2] = '{"signed_s0", 1, fill(16'h0000, 2, 16'h0100, 5, 16'hFF00), '0, 16'h0100,
                pack(4'd5, 16'hFF00, 4'd2, 17'h0FE00, 1'b1)};
    vecs[3] = '{"tie_first", 0, fill(16'h0010, 1, 16'h0200, 8, 16'h0200), '0, 16'h0001,
                pack(4'd1, 16'h0200, 4'd8, 17'h0, 1'b0)};
    vecs[4] = '{"tie_last",  2, fill(16'h0010, 1, 16'h0200, 8, 16'h0200), '0, 16'h0001,
                pack(4'd8, 16'h0200, 4'd1, 17'h0, 1'b0)};
    vecs[5] = '{"n1",        3, fill(16'h1234, 0, 16'h1234, 0, 16'h1234), '0, 16'h0000,
                pack(4'd0, 16'h1234, 4'd0, 17'h0, 1'b1)};
    vecs[6] = '{"ramp16",    4, fill(16'h0040, 3, 16'h0480, 7, 16'h0300), ramp, 16'h0005,
                pack(4'd0, 16'h0078, 4'd1, 17'h5, 1'b1)};
    vecs[7] = '{"thr_above", 0, fill(16'h0040, 3, 16'h0480, 7, 16'h0300), '0, 16'h0181,
                pack(4'd3, 16'h0480, 4'd7, 17'h00180, 1'b0)};
    vecs[8] = '{"thr_equal", 0, fill(16'h0040, 3, 16'h0480, 7, 16'h0300), '0, 16'h0180, exp_def};

    // Reset state, checked while reset is still asserted.
    #12;
    for (int k = 0; k < 5; k++) chk_res($sformatf("reset%0d", k), get_res(k), '0);
    chk("reset.busy", 64'(busy_vec), 64'd0);
    chk("reset.done", 64'(done_vec), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      scores   = vecs[v].sc;
      scores16 = vecs[v].sc16;
      thr      = vecs[v].th;
      run_inst(vecs[v].inst, vecs[v].name, vecs[v].exp);
    end

    // Asynchronous reset in the middle of a scan.
    scores = vecs[0].sc; thr = vecs[0].th;
    do_start(1);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.busy", 64'(busy0), 64'd0);
    chk("rst_mid.done", 64'(done0), 64'd0);
    chk_res("rst_mid", get_res(0), '0);
    #3 rst = 1'b0;
    n = 0;
    repeat (20) begin @(posedge clk); #1; if (done0) n++; end
    chk("rst_mid.no_done", 64'(n), 64'd0);
    run_inst(0, "post_rst", exp_def);

    // Start while busy plus a change of scores mid-run: original snapshot must win.
    scores = vecs[0].sc; thr = vecs[0].th;
    do_start(1);
    repeat (2) begin @(posedge clk); #1; end
    scores = vecs[3].sc;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    n = 0; got = '0;
    repeat (30) begin @(posedge clk); #1; if (done0) begin n++; got = get_res(0); end end
    chk("busy_start.done_count", 64'(n), 64'd1);
    chk_res("busy_start", got, exp_def);

    // Start held for two cycles yields a single run.
    scores = vecs[0].sc;
    do_start(2);
    n = 0;
    repeat (30) begin @(posedge clk); #1; if (done0) n++; end
    chk("hold_start.done_count", 64'(n), 64'd1);

    // Randomized runs against the reference model.
    for (int r = 0; r < 25; r++) begin
      int lat, bc;
      for (int i = 0; i < 10; i++) scores[i*16 +: 16] = rnd_score();
      thr = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h0400)) : 16'($urandom);
      exp_q.push_back(model(scores, 1'b1, 1'b0, thr));
      exp_q.push_back(model(scores, 1'b0, 1'b0, thr));
      exp_q.push_back(model(scores, 1'b1, 1'b1, thr));
      exp_q.push_back(pack(4'd0, scores[15:0], 4'd0, 17'd0, thr == 16'd0));
      do_start(1);
      wait_done(0, lat, bc);
      chk($sformatf("rnd%0d.latency", r), 64'(lat), 64'd11);
      for (int k = 0; k < 4; k++) chk_res($sformatf("rnd%0d.u%0d", r, k), get_res(k), exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
